// File: rtl/cla_multiword_add_seq.sv
// rtl/cla_multiword_add_seq.sv - multiword adder sequencer chaining CLA beats over valid/ready streams

// Carry-lookahead adder: each carry is a flat OR of generate terms gated by propagate runs.
module carry_lookahead_adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, built without referring to other carries
  always_comb begin
    logic acc;
    logic pp;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      acc = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[i+1] = acc | (pp & cin);
    end
    sum  = p ^ c[WIDTH-1:0];
    cout = c[WIDTH];
  end

endmodule

module cla_multiword_add_seq #(
  parameter int WIDTH     = 16,
  parameter int MAX_WORDS = 8,
  parameter int NW_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NW_W-1:0]  num_words,
  input  logic             carry_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_last,
  output logic             out_carry,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [NW_W-1:0]  nw_reg;
  logic [NW_W-1:0]  beat_cnt;
  logic             carry_reg;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             accept;
  logic             is_last;
  logic             nw_legal;
  logic             start_ok;

  carry_lookahead_adder #(.WIDTH(WIDTH)) u_cla (
    .a    (in_a),
    .b    (in_b),
    .cin  (carry_reg),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign nw_legal = (num_words != '0) && (num_words <= NW_W'(MAX_WORDS));
  assign start_ok = (state == IDLE) && start && nw_legal;
  assign accept   = in_valid && in_ready;
  assign is_last  = (beat_cnt == (nw_reg - NW_W'(1)));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: RUN until the last beat is accepted, FLUSH until that beat is drained
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = RUN;
      RUN:     if (accept && is_last) state_nxt = FLUSH;
      FLUSH:   if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and status outputs derived from state and the output stage
  always_comb begin
    in_ready = (state == RUN) && (!out_valid || out_ready);
    busy     = (state != IDLE);
    done     = (state == FLUSH) && out_valid && out_ready;
  end

  // Operation context, carry chain and the one-entry output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      nw_reg    <= '0;
      beat_cnt  <= '0;
      carry_reg <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_last  <= 1'b0;
      out_carry <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= (state == IDLE) && start && !nw_legal;
      if (start_ok) begin
        nw_reg    <= num_words;
        carry_reg <= carry_in;
        beat_cnt  <= '0;
      end
      if (accept) begin
        out_sum   <= add_sum;
        out_valid <= 1'b1;
        out_last  <= is_last;
        out_carry <= is_last ? add_cout : 1'b0;
        carry_reg <= add_cout;
        beat_cnt  <= beat_cnt + NW_W'(1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cla_multiword_add_seq.sv
// tb/tb_cla_multiword_add_seq.sv - randomized self-checking bench for cla_multiword_add_seq

module tb_cla_multiword_add_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  num_words = '0;
  logic        carry_in = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_sum;
  logic        out_last;
  logic        out_carry;
  logic        busy;
  logic        done;
  logic        err;

  cla_multiword_add_seq #(.WIDTH(16), .MAX_WORDS(8), .NW_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words), .carry_in(carry_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_last(out_last), .out_carry(out_carry), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] s;
    logic        l;
    logic        c;
  } beat_t;

  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  int          cyc = 0;
  bit          stall_on = 1'b0;
  bit          exp_busy = 1'b0;
  bit          clear_pending = 1'b0;
  bit          err_ok = 1'b0;
  beat_t       exp_q[$];
  logic [15:0] rec_sum[$];
  logic        rec_last[$];
  logic        rec_carry[$];
  int          rec_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic clear_rec();
    rec_sum.delete();
    rec_last.delete();
    rec_carry.delete();
    rec_cyc.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_sum"},   32'(out_sum),   32'd0);
    chk({tag, "_out_last"},  32'(out_last),  32'd0);
    chk({tag, "_out_carry"}, 32'(out_carry), 32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_done"},      32'(done),      32'd0);
    chk({tag, "_err"},       32'(err),       32'd0);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
  endtask

  // Output consumer: always ready, or randomly stalling
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = stall_on ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Compare process: every negedge, check the output stream against the expected beat queue
  initial begin : cmp
    logic        held_v;
    logic [15:0] hs;
    logic        hl;
    logic        hc;
    beat_t       e;
    held_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_v = 1'b0;
      end else begin
        if (clear_pending) begin
          exp_busy = 1'b0;
          clear_pending = 1'b0;
        end
        chk("busy", 32'(busy), 32'(exp_busy));
        if (!err_ok) chk("err_quiet", 32'(err), 32'd0);
        if (!busy) chk("in_ready_idle", 32'(in_ready), 32'd0);
        if (held_v) begin
          chk("stall_valid", 32'(out_valid), 32'd1);
          chk("stall_sum",   32'(out_sum),   32'(hs));
          chk("stall_last",  32'(out_last),  32'(hl));
          chk("stall_carry", 32'(out_carry), 32'(hc));
        end
        held_v = 1'b0;
        if (out_valid && !out_ready) begin
          chk("no_overwrite", 32'(in_ready), 32'd0);
          held_v = 1'b1;
          hs = out_sum;
          hl = out_last;
          hc = out_carry;
        end
        if (out_valid && out_ready) begin
          rec_sum.push_back(out_sum);
          rec_last.push_back(out_last);
          rec_carry.push_back(out_carry);
          rec_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_beat act=%h exp=none", out_sum);
          end else begin
            e = exp_q.pop_front();
            chk("sum",  32'(out_sum),  32'(e.s));
            chk("last", 32'(out_last), 32'(e.l));
            if (e.l) chk("carry", 32'(out_carry), 32'(e.c));
            chk("done_on_beat", 32'(done), 32'(e.l));
            if (e.l) clear_pending = 1'b1;
          end
        end else begin
          chk("done_quiet", 32'(done), 32'd0);
        end
        if (done) done_cnt++;
      end
    end
  end

  // One full operation: model the wide sum, push expected beats, feed operands, wait for done
  task automatic run_op(input int nw, input logic cin, input logic [127:0] a, input logic [127:0] b,
                        input bit rand_valid, input int abort_after, input bit noise);
    logic [128:0] m;
    logic [128:0] full;
    beat_t        e;
    int           i;
    int           guard;
    int           target;
    bit           acc;
    m    = (129'd1 << (nw * 16)) - 129'd1;
    full = {1'b0, a & m[127:0]} + {1'b0, b & m[127:0]} + 129'(cin);
    for (int k = 0; k < nw; k++) begin
      e.s = full[16*k +: 16];
      e.l = (k == nw - 1);
      e.c = e.l ? full[16*nw] : 1'b0;
      exp_q.push_back(e);
    end
    target = done_cnt + 1;
    @(posedge clk);
    #1;
    start = 1'b1;
    num_words = 4'(nw);
    carry_in = cin;
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_busy = 1'b1;
    i = 0;
    guard = 0;
    while (i < nw && guard < 1000) begin
      in_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      in_a = a[16*i +: 16];
      in_b = b[16*i +: 16];
      if (noise && i >= 1) begin
        start = 1'b1;
        num_words = 4'd0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) i++;
      guard++;
      if (abort_after >= 0 && i == abort_after) begin
        rst = 1'b1;
        in_valid = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_busy = 1'b0;
        clear_pending = 1'b0;
        check_zero("abort_reset");
        return;
      end
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (i < nw) begin
      total++;
      bad++;
      $display("FAIL feed_timeout act=%0d exp=%0d", i, nw);
    end
    guard = 0;
    while (done_cnt < target && guard < 1000) begin
      @(posedge clk);
      guard++;
    end
    if (done_cnt < target) begin
      total++;
      bad++;
      $display("FAIL done_timeout act=%0d exp=%0d", done_cnt, target);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_zero("reset");

    // T1: single beat with carry out
    clear_rec();
    run_op(1, 1'b0, 128'hFFFF, 128'h0001, 1'b0, -1, 1'b0);
    chk("t1_count", 32'(rec_sum.size()), 32'd1);
    if (rec_sum.size() == 1) begin
      chk("t1_sum",   32'(rec_sum[0]),   32'h0000);
      chk("t1_last",  32'(rec_last[0]),  32'd1);
      chk("t1_carry", 32'(rec_carry[0]), 32'd1);
    end

    // T2: carry ripples across two beat boundaries
    clear_rec();
    run_op(3, 1'b1, 128'h0000_FFFF_FFFF, 128'h0, 1'b0, -1, 1'b0);
    chk("t2_count", 32'(rec_sum.size()), 32'd3);
    if (rec_sum.size() == 3) begin
      chk("t2_sum0",  32'(rec_sum[0]),   32'h0000);
      chk("t2_sum1",  32'(rec_sum[1]),   32'h0000);
      chk("t2_sum2",  32'(rec_sum[2]),   32'h0001);
      chk("t2_last0", 32'(rec_last[0]),  32'd0);
      chk("t2_carry", 32'(rec_carry[2]), 32'd0);
    end

    // T3: random 64-bit operations with consumer stalls and gappy input
    stall_on = 1'b1;
    for (int n = 0; n < 10; n++)
      run_op(4, 1'($urandom_range(0, 1)), rnd128(), rnd128(), 1'b1, -1, 1'b0);
    stall_on = 1'b0;

    // T4: illegal num_words, then start while busy
    err_ok = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b1;
    num_words = 4'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("t4_err0", 32'(err), 32'd1);
    chk("t4_busy0", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    chk("t4_err0_pulse", 32'(err), 32'd0);
    start = 1'b1;
    num_words = 4'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("t4_err9", 32'(err), 32'd1);
    chk("t4_busy9", 32'(busy), 32'd0);
    chk("t4_noout", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("t4_err9_pulse", 32'(err), 32'd0);
    err_ok = 1'b0;
    run_op(4, 1'b0, rnd128(), rnd128(), 1'b0, -1, 1'b1);

    // T5: reset after beat 1 of 4 with a live carry, then a clean operation
    run_op(4, 1'b1, {128{1'b1}}, {128{1'b1}}, 1'b0, 1, 1'b0);
    clear_rec();
    run_op(4, 1'b0, 128'h0, 128'h0, 1'b0, -1, 1'b0);
    chk("t5_count", 32'(rec_sum.size()), 32'd4);
    if (rec_sum.size() == 4) chk("t5_sum0", 32'(rec_sum[0]), 32'h0000);

    // T6: back-to-back full-rate operations, carry not chained between them
    clear_rec();
    run_op(8, 1'b0, {128{1'b1}}, 128'h1, 1'b0, -1, 1'b0);
    run_op(8, 1'b1, 128'h0, 128'h0, 1'b0, -1, 1'b0);
    chk("t6_count", 32'(rec_sum.size()), 32'd16);
    if (rec_sum.size() == 16) begin
      chk("t6_rate0",   32'(rec_cyc[7] - rec_cyc[0]),  32'd7);
      chk("t6_rate1",   32'(rec_cyc[15] - rec_cyc[8]), 32'd7);
      chk("t6_carry0",  32'(rec_carry[7]),  32'd1);
      chk("t6_sum8",    32'(rec_sum[8]),    32'h0001);
      chk("t6_sum9",    32'(rec_sum[9]),    32'h0000);
      chk("t6_carry1",  32'(rec_carry[15]), 32'd0);
    end

    // Random lengths and mixed conditions
    stall_on = 1'b1;
    for (int n = 0; n < 12; n++)
      run_op($urandom_range(1, 8), 1'($urandom_range(0, 1)), rnd128(), rnd128(), 1'($urandom_range(0, 1)), -1, 1'b0);
    stall_on = 1'b0;

    repeat (3) @(posedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
